// File: rtl/md_if.sv
// Request/response bundle between the E-stage controller and the
// multiply/divide unit.
interface md_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        multctrl;
  logic [1:0]        muwe;
  logic [1:0]        mure;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, multctrl, muwe, mure, a, b,
    input  busy, result, hi, lo
  );

  modport slave (
    input  start, multctrl, muwe, mure, a, b,
    output busy, result, hi, lo
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// The 64-bit result is computed at launch and parked in pending registers;
// HI/LO only change when the busy countdown expires, so architectural state
// never shows a result early.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      pend_hi_q, pend_lo_q;
  logic             pend_wr_q;

  logic             op_valid, is_div, is_signed, div_zero;
  logic             launch, done;
  logic [63:0]      res64;

  // 32x32 -> 64 multiply; operands are sign- or zero-extended to 64 bits so
  // the truncated 64-bit product is exact in both cases.
  function automatic logic [63:0] mul_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic sgn);
    logic [63:0] xe, ye;
    xe = sgn ? {{32{x[31]}}, x} : {32'b0, x};
    ye = sgn ? {{32{y[31]}}, y} : {32'b0, y};
    return xe * ye;
  endfunction

  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder takes the dividend's sign. 0x80000000 / -1 falls out naturally
  // as quotient 0x80000000, remainder 0. A zero divisor is replaced by 1 only
  // to keep the arithmetic defined; that result is never committed.
  function automatic logic [63:0] div_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic sgn);
    logic        xn, yn;
    logic [31:0] xm, ym, qm, rm, q, r;
    xn = sgn & x[31];
    yn = sgn & y[31];
    xm = xn ? -x : x;
    ym = yn ? -y : y;
    if (ym == 32'd0) ym = 32'd1;
    qm = xm / ym;
    rm = xm % ym;
    q  = (xn ^ yn) ? -qm : qm;
    r  = xn ? -rm : rm;
    return {r, q};
  endfunction

  assign op_valid  = ~bus.multctrl[2];
  assign is_div    = bus.multctrl[1];
  assign is_signed = ~bus.multctrl[0];
  assign div_zero  = is_div && (bus.b == 32'd0);
  assign launch    = (state_q == IDLE) && bus.start && op_valid;
  assign done      = (state_q == BUSY) && (cnt_q == CNT_ONE);

  // Operation result for the request currently on the inputs.
  always_comb begin
    res64 = 64'd0;
    if (is_div) res64 = div_fn(bus.a, bus.b, is_signed);
    else        res64 = mul_fn(bus.a, bus.b, is_signed);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: launch on a valid start, return to IDLE when the countdown ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = BUSY;
      BUSY:    if (done)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Countdown, pending result capture, HI/LO commit and mthi/mtlo writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else if (launch) begin
      pend_hi_q <= res64[63:32];
      pend_lo_q <= res64[31:0];
      pend_wr_q <= ~div_zero;
      cnt_q     <= is_div ? DIV_N : MULT_N;
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - CNT_ONE;
      if (done && pend_wr_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end else if (!bus.start) begin
      case (bus.muwe)
        2'b01:   hi_q <= bus.a;
        2'b10:   lo_q <= bus.a;
        default: ;
      endcase
    end
  end

  // Read port: architectural HI/LO only, no bypass.
  always_comb begin
    case (bus.mure)
      2'b01:   bus.result = hi_q;
      2'b10:   bus.result = lo_q;
      default: bus.result = 32'd0;
    endcase
  end

  assign bus.busy = (state_q == BUSY);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide responder for the P6 pipeline; sits in the E stage beside the ALU.
- Accepts the start / multctrl / muwe / mure requests the E-stage controller issues. Runs multi-cycle mult/multu/div/divu into private HI/LO registers.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Exposes busy so the D-stage hazard logic stalls any mult/div-class instruction (ismu) while start or busy is high.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (>=1)
- DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: launch the operation selected by multctrl using a, b
- multctrl  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, others = no-op
- muwe  input  2  HI/LO write: 01 mthi (HI<=a), 10 mtlo (LO<=a), 00/11 none
- mure  input  2  HI/LO read select: 01 HI, 10 LO, 00/11 zero
- a  input  32  operand rs (forwarded value)
- b  input  32  operand rt (forwarded value)
- busy  output  1  operation in flight
- result  output  32  combinational read of HI/LO per mure
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Reset (synchronous, active-high): HI=0, LO=0, busy=0, counter=0, pending registers=0. Reset mid-operation aborts it; HI/LO stay 0 and busy=0 next cycle.
- State machine:
  - IDLE (busy=0): on a rising edge with start=1 and a valid multctrl, latch the computed 64-bit result into pending_hi/pending_lo. Load counter with MULT_CYCLES or DIV_CYCLES. Go to BUSY.
  - BUSY (busy=1): counter decrements each cycle. When counter==1, on that edge copy pending into HI/LO, clear busy, return to IDLE.
- Latency timing: start sampled at edge T. busy=1 during cycles T+1 .. T+N (N = MULT_CYCLES or DIV_CYCLES). New HI/LO visible and busy=0 from cycle T+N+1.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI = upper, LO = lower.
  - multu: the same, unsigned.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend a.
  - divu: the same, unsigned.
- Divide by zero (b==0, div or divu): full DIV_CYCLES busy period still runs; HI/LO are left unchanged at completion.
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- start with invalid multctrl: ignored; stay IDLE.
- start while busy: ignored; the in-flight operation is not disturbed. The hazard unit must not issue it.
- muwe in IDLE with start=0: the selected register is written with a at that edge; visible next cycle.
- muwe while busy, or muwe with start in the same cycle: ignored; start wins.
- result:
  - Purely combinational from the current HI/LO registers; no bypass of pending values or same-cycle muwe.
  - mure 01 -> HI, 10 -> LO, otherwise 0x00000000.
- hi/lo outputs always equal the architectural HI/LO registers; never show pending values before completion.

Test Plan:
- Reset, then mult a=0xFFFFFFFF b=0x00000002 -> busy=1 for exactly 5 cycles. Afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFE; mure=10 gives result=0xFFFFFFFE.
- multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles. During busy, hi/lo still show the previous values.
- div a=0xFFFFFFF9 (-7) b=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu a=7 b=2 -> LO=3, HI=1.
- With HI=0x12345678, LO=0x9ABCDEF0: divu a=7 b=0 -> busy 10 cycles, then HI/LO unchanged. A second start pulsed mid-busy -> ignored; busy still drops on schedule.
- mthi (muwe=01, a=0xDEADBEEF) in IDLE -> next cycle mure=01 gives 0xDEADBEEF. mtlo during busy -> LO unaffected. muwe and start in the same cycle -> only the operation takes effect.
- Start a mult, assert reset on busy cycle 3 -> next cycle busy=0, HI=LO=0; completion never occurs.
